// File: rtl/tiny_cpu_sequencer_if.sv
// Host/datapath bundle for tiny_cpu_sequencer.
// master: host + datapath side; slave: the sequencer.
interface tiny_cpu_sequencer_if;
    // host job request
    logic       start;
    logic       abort;
    logic [3:0] seed;
    logic [3:0] opcode_in;
    logic [2:0] nsteps;
    logic       halt_on_zero;
    // datapath feedback and drive
    logic [3:0] acc_res;
    logic       dp_mode;
    logic [3:0] dp_opcode;
    logic [3:0] dp_seed;
    // host status
    logic       busy;
    logic       done;
    logic [3:0] result;
    logic [2:0] steps_done;
    logic       zero_stop;

    modport master (
        output start, abort, seed, opcode_in, nsteps, halt_on_zero,
        output acc_res,
        input  dp_mode, dp_opcode, dp_seed,
        input  busy, done, result, steps_done, zero_stop
    );

    modport slave (
        input  start, abort, seed, opcode_in, nsteps, halt_on_zero,
        input  acc_res,
        output dp_mode, dp_opcode, dp_seed,
        output busy, done, result, steps_done, zero_stop
    );
endinterface

// File: rtl/tiny_cpu_sequencer.sv
// Load/execute sequencer for the 4-bit accumulator datapath.
// Ports: clk, rst (async, active-high), bus (slave side of job/datapath bundle).
module tiny_cpu_sequencer #(
    parameter int STEPS_MAX = 6
) (
    input logic                  clk,
    input logic                  rst,
    tiny_cpu_sequencer_if.slave  bus
);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        EXEC,
        DRAIN
    } state_t;

    state_t     state_q;
    state_t     state_d;
    logic [3:0] cnt_q;
    logic [3:0] cnt_d;
    logic       zflag_q;
    logic       zflag_d;

    logic [3:0] seed_q;
    logic [3:0] op_q;
    logic [2:0] nsteps_q;
    logic       hoz_q;

    logic       dp_mode_q;
    logic       busy_q;
    logic       done_q;
    logic [3:0] result_q;
    logic [2:0] steps_q;
    logic       zstop_q;

    logic [3:0] target;
    logic       accept;
    logic       finish;

    assign target = (nsteps_q == 3'd0) ? 4'(STEPS_MAX)
                                       : {1'b0, nsteps_q};
    assign accept = (state_q == IDLE) && bus.start;
    // abort in DRAIN also suppresses the capture
    assign finish = (state_q == DRAIN) && !bus.abort;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        zflag_d = zflag_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LOAD;
                    cnt_d   = 4'd0;
                    zflag_d = 1'b0;
                end
            end
            LOAD: begin
                state_d = EXEC;
            end
            EXEC: begin
                // this cycle counts as a step whichever way we leave
                cnt_d = cnt_q + 4'd1;
                if (cnt_d == target) begin
                    state_d = DRAIN;
                end
                if (hoz_q && (bus.acc_res == 4'd0)) begin
                    state_d = DRAIN;
                    zflag_d = 1'b1;
                end
            end
            DRAIN: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
        if (bus.abort && (state_q != IDLE)) begin
            state_d = IDLE;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q   <= IDLE;
            cnt_q     <= 4'd0;
            zflag_q   <= 1'b0;
            seed_q    <= 4'd0;
            op_q      <= 4'd0;
            nsteps_q  <= 3'd0;
            hoz_q     <= 1'b0;
            dp_mode_q <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            result_q  <= 4'd0;
            steps_q   <= 3'd0;
            zstop_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            zflag_q   <= zflag_d;
            dp_mode_q <= (state_d == EXEC);
            busy_q    <= (state_d != IDLE);
            done_q    <= finish;
            if (accept) begin
                seed_q   <= bus.seed;
                op_q     <= bus.opcode_in;
                nsteps_q <= bus.nsteps;
                hoz_q    <= bus.halt_on_zero;
            end
            if (finish) begin
                result_q <= bus.acc_res;
                steps_q  <= cnt_q[2:0];
                zstop_q  <= zflag_q;
            end
        end
    end

    assign bus.dp_mode    = dp_mode_q;
    assign bus.dp_opcode  = op_q;
    assign bus.dp_seed    = seed_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.result     = result_q;
    assign bus.steps_done = steps_q;
    assign bus.zero_stop  = zstop_q;

endmodule
